// File: rtl/alien_march_scheduler_pkg.sv
// Shared definitions for the alien march scheduler.
// - game_state_e : game-phase encoding, also driven out on Game_State
// - counter widths and default timing constants
// - step_period(): frames-per-step for a given live alien count
package alien_march_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MARCH      = 3'd1,
    ST_PAUSED     = 3'd2,
    ST_WAVE_CLEAR = 3'd3,
    ST_GAME_OVER  = 3'd4
  } game_state_e;

  localparam int FRAME_CNT_W    = 7;
  localparam int WAVE_CNT_W     = 8;
  localparam int ALIVE_W        = 6;
  localparam int MIN_PERIOD_DEF = 2;
  localparam int WAVE_DELAY_DEF = 120;
  localparam int MAX_ALIVE_DEF  = 55;
  localparam logic [3:0] WAVE_NUM_MAX = 4'd15;

  // Largest result is 2 + 63 = 65, so 7 bits never overflow.
  function automatic logic [FRAME_CNT_W-1:0] step_period(
    input int                 min_period,
    input logic [ALIVE_W-1:0] alive
  );
    return FRAME_CNT_W'(min_period) + {1'b0, alive};
  endfunction

endpackage

// File: rtl/alien_march_scheduler_if.sv
// Signal bundle between the scheduler and its neighbours.
// Inputs to the scheduler : Frame_Tick, Start, Pause, AliensAlive, Reached_Bottom
// Outputs of the scheduler: Step_En, Anim_Frame, Step_Note, Wave_Restart,
//                           Game_State, Wave_Num
// master = environment side (frame tick generator, collision logic, mover)
// slave  = scheduler side
// Handshake: there is no back-pressure. Step_En and Wave_Restart are
// single-cycle pulses; the consumer must act on every cycle they are high.
interface alien_march_scheduler_if;
  import alien_march_scheduler_pkg::*;

  logic               Frame_Tick;
  logic               Start;
  logic               Pause;
  logic [ALIVE_W-1:0] AliensAlive;
  logic               Reached_Bottom;
  logic               Step_En;
  logic               Anim_Frame;
  logic [1:0]         Step_Note;
  logic               Wave_Restart;
  logic [2:0]         Game_State;
  logic [3:0]         Wave_Num;

  modport master (
    output Frame_Tick, Start, Pause, AliensAlive, Reached_Bottom,
    input  Step_En, Anim_Frame, Step_Note, Wave_Restart, Game_State, Wave_Num
  );

  modport slave (
    input  Frame_Tick, Start, Pause, AliensAlive, Reached_Bottom,
    output Step_En, Anim_Frame, Step_Note, Wave_Restart, Game_State, Wave_Num
  );
endinterface

// File: rtl/alien_march_scheduler_frame_divider.sv
// Counts qualified frame ticks against a limit.
// Ports: clk, rst_n (sync active-low), clear (zero the count, wins over tick),
//        tick (qualified frame tick), limit (ticks per period),
//        done (combinational: this tick completes the period; count wraps to 0).
module alien_march_scheduler_frame_divider #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   next_cnt;

  // One extra bit so the compare is immune to wrap at the top of the range.
  assign next_cnt = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
  assign done     = tick && (next_cnt >= {1'b0, limit});

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = done ? '0 : next_cnt[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/alien_march_scheduler.sv
// Alien formation march scheduler and game-phase FSM.
// Ports: Clk, Reset_n (sync active-low), bus (slave side of
// alien_march_scheduler_if). Game_State exposes the FSM state directly.
// All outputs are registered: a qualifying Frame_Tick produces Step_En on the
// following cycle, and the step period is relatched only when a step fires.
module alien_march_scheduler
  import alien_march_scheduler_pkg::*;
#(
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int WAVE_DELAY = WAVE_DELAY_DEF,
  parameter int MAX_ALIVE  = MAX_ALIVE_DEF
) (
  input logic                  Clk,
  input logic                  Reset_n,
  alien_march_scheduler_if.slave bus
);

  localparam logic [ALIVE_W-1:0]    FULL_ALIVE = ALIVE_W'(MAX_ALIVE);
  localparam logic [WAVE_CNT_W-1:0] WAVE_LIM   = WAVE_CNT_W'(WAVE_DELAY);

  game_state_e            state_q, state_d;
  logic                   start_q;
  logic                   step_en_q, step_en_d;
  logic                   anim_q, anim_d;
  logic [1:0]             note_q, note_d;
  logic                   restart_q, restart_d;
  logic [3:0]             wave_num_q, wave_num_d;
  logic [FRAME_CNT_W-1:0] period_q, period_d;

  logic start_rise;
  logic alive_zero;
  logic march_tick, march_clear, march_done;
  logic wave_tick, wave_clear, wave_done;

  // Start must be released and reasserted to leave IDLE.
  assign start_rise = bus.Start && !start_q;
  assign alive_zero = (bus.AliensAlive == '0);

  // March counter only advances in MARCH when no higher-priority exit applies.
  assign march_tick  = (state_q == ST_MARCH) && !bus.Reached_Bottom && !alive_zero
                       && !bus.Pause && bus.Frame_Tick;
  assign wave_clear  = (state_q == ST_MARCH) && !bus.Reached_Bottom && alive_zero;
  assign wave_tick   = (state_q == ST_WAVE_CLEAR) && bus.Frame_Tick;
  assign march_clear = ((state_q == ST_IDLE) && start_rise) || wave_clear
                       || ((state_q == ST_WAVE_CLEAR) && wave_done);

  alien_march_scheduler_frame_divider #(.W(FRAME_CNT_W)) u_march_div (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (march_clear),
    .tick  (march_tick),
    .limit (period_q),
    .done  (march_done)
  );

  alien_march_scheduler_frame_divider #(.W(WAVE_CNT_W)) u_wave_div (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (wave_clear),
    .tick  (wave_tick),
    .limit (WAVE_LIM),
    .done  (wave_done)
  );

  // State register (plus registered outputs)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      step_en_q  <= 1'b0;
      anim_q     <= 1'b0;
      note_q     <= 2'd0;
      restart_q  <= 1'b0;
      wave_num_q <= 4'd0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.Start;
      step_en_q  <= step_en_d;
      anim_q     <= anim_d;
      note_q     <= note_d;
      restart_q  <= restart_d;
      wave_num_q <= wave_num_d;
      period_q   <= period_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_MARCH;
      ST_MARCH: begin
        if (bus.Reached_Bottom) state_d = ST_GAME_OVER;
        else if (alive_zero)    state_d = ST_WAVE_CLEAR;
        else if (bus.Pause)     state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.Reached_Bottom) state_d = ST_GAME_OVER;
        else if (!bus.Pause)    state_d = ST_MARCH;
      end
      ST_WAVE_CLEAR: if (wave_done) state_d = ST_MARCH;
      ST_GAME_OVER:  if (bus.Start) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    step_en_d  = 1'b0;
    restart_d  = 1'b0;
    anim_d     = anim_q;
    note_d     = note_q;
    wave_num_d = wave_num_q;
    period_d   = period_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          restart_d = 1'b1;
          period_d  = step_period(MIN_PERIOD, FULL_ALIVE);
        end
      end
      ST_MARCH: begin
        if (march_done) begin
          step_en_d = 1'b1;
          anim_d    = ~anim_q;
          note_d    = note_q + 2'd1;
          period_d  = step_period(MIN_PERIOD, bus.AliensAlive);
        end
      end
      ST_WAVE_CLEAR: begin
        if (wave_done) begin
          restart_d = 1'b1;
          period_d  = step_period(MIN_PERIOD, FULL_ALIVE);
          if (wave_num_q != WAVE_NUM_MAX) wave_num_d = wave_num_q + 4'd1;
        end
      end
      ST_GAME_OVER: begin
        if (bus.Start) wave_num_d = 4'd0;
      end
      default: ;
    endcase
  end

  assign bus.Step_En      = step_en_q;
  assign bus.Anim_Frame   = anim_q;
  assign bus.Step_Note    = note_q;
  assign bus.Wave_Restart = restart_q;
  assign bus.Game_State   = state_q;
  assign bus.Wave_Num     = wave_num_q;

endmodule

// File: tb/tb_alien_march_scheduler.sv
module tb_alien_march_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alien_march_scheduler_if bus();

  alien_march_scheduler dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] alive;
    int         exp_ticks;
    logic       exp_anim;
    logic [1:0] exp_note;
  } step_vec_t;

  step_vec_t vecs[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Nine idle cycles after a tick; a step must never appear here.
  task automatic gap();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (bus.Step_En) seen = 1'b1;
    end
    chk("single_step", {31'd0, seen}, 32'd0);
  endtask

  task automatic tick_edge();
    bus.Frame_Tick = 1'b1;
    cyc();
    bus.Frame_Tick = 1'b0;
  endtask

  task automatic frame(output logic stepped);
    tick_edge();
    stepped = bus.Step_En;
    gap();
  endtask

  task automatic frames_no_step(input int n, input string name);
    logic st;
    logic any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      frame(st);
      if (st) any = 1'b1;
    end
    chk(name, {31'd0, any}, 32'd0);
  endtask

  // Count frames until a step; bounded so a dead scheduler cannot hang the run.
  task automatic wait_step(output int n);
    logic st;
    n  = 0;
    st = 1'b0;
    while (!st && n < 200) begin
      frame(st);
      n++;
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;

    vecs[0] = '{alive: 6'd1,  exp_ticks: 57, exp_anim: 1'b1, exp_note: 2'd1};
    vecs[1] = '{alive: 6'd1,  exp_ticks: 3,  exp_anim: 1'b0, exp_note: 2'd2};
    vecs[2] = '{alive: 6'd1,  exp_ticks: 3,  exp_anim: 1'b1, exp_note: 2'd3};
    vecs[3] = '{alive: 6'd10, exp_ticks: 3,  exp_anim: 1'b0, exp_note: 2'd0};
    vecs[4] = '{alive: 6'd10, exp_ticks: 12, exp_anim: 1'b1, exp_note: 2'd1};
    vecs[5] = '{alive: 6'd55, exp_ticks: 12, exp_anim: 1'b0, exp_note: 2'd2};

    rst_n              = 1'b0;
    bus.Frame_Tick     = 1'b0;
    bus.Start          = 1'b0;
    bus.Pause          = 1'b0;
    bus.AliensAlive    = 6'd55;
    bus.Reached_Bottom = 1'b0;
    repeat (3) cyc();

    chk("rst_state",   32'(bus.Game_State),   32'd0);
    chk("rst_step",    32'(bus.Step_En),      32'd0);
    chk("rst_anim",    32'(bus.Anim_Frame),   32'd0);
    chk("rst_note",    32'(bus.Step_Note),    32'd0);
    chk("rst_restart", 32'(bus.Wave_Restart), 32'd0);
    chk("rst_wave",    32'(bus.Wave_Num),     32'd0);

    rst_n = 1'b1;
    cyc();
    bus.Start = 1'b1;
    cyc();
    chk("start_state",   32'(bus.Game_State),   32'd1);
    chk("start_restart", 32'(bus.Wave_Restart), 32'd1);
    bus.Start = 1'b0;
    cyc();
    chk("restart_width", 32'(bus.Wave_Restart), 32'd0);

    // Step rate table: the period for each step was latched at the previous step.
    for (int i = 0; i < 6; i++) begin
      bus.AliensAlive = vecs[i].alive;
      wait_step(n);
      chk($sformatf("v%0d_ticks", i), 32'(n),              32'(vecs[i].exp_ticks));
      chk($sformatf("v%0d_anim", i),  32'(bus.Anim_Frame), 32'(vecs[i].exp_anim));
      chk($sformatf("v%0d_note", i),  32'(bus.Step_Note),  32'(vecs[i].exp_note));
    end

    // Pause at counter 30 for 20 ticks; 27 more ticks complete the 57.
    frames_no_step(30, "pre_pause_nostep");
    bus.Pause = 1'b1;
    cyc();
    chk("paused_state", 32'(bus.Game_State), 32'd2);
    frames_no_step(20, "paused_nostep");
    bus.Pause = 1'b0;
    cyc();
    chk("resume_state", 32'(bus.Game_State), 32'd1);
    wait_step(n);
    chk("resume_ticks", 32'(n),              32'd27);
    chk("resume_anim",  32'(bus.Anim_Frame), 32'd1);
    chk("resume_note",  32'(bus.Step_Note),  32'd3);

    // Wave clear with Pause held high, which must be ignored.
    bus.AliensAlive = 6'd0;
    cyc();
    chk("wc_state", 32'(bus.Game_State), 32'd3);
    bus.Pause = 1'b1;
    frames_no_step(119, "wc_nostep");
    chk("wc_hold_state", 32'(bus.Game_State),   32'd3);
    chk("wc_hold_rst",   32'(bus.Wave_Restart), 32'd0);
    tick_edge();
    chk("wc_done_state",   32'(bus.Game_State),   32'd1);
    chk("wc_done_restart", 32'(bus.Wave_Restart), 32'd1);
    chk("wc_done_wave",    32'(bus.Wave_Num),     32'd1);
    bus.Pause       = 1'b0;
    bus.AliensAlive = 6'd55;
    gap();
    chk("wc_after_restart", 32'(bus.Wave_Restart), 32'd0);
    chk("wc_after_state",   32'(bus.Game_State),   32'd1);

    // Reached_Bottom wins over AliensAlive==0.
    frames_no_step(5, "pre_go_nostep");
    bus.AliensAlive    = 6'd0;
    bus.Reached_Bottom = 1'b1;
    cyc();
    chk("go_state", 32'(bus.Game_State), 32'd4);
    chk("go_wave",  32'(bus.Wave_Num),   32'd1);
    bus.Reached_Bottom = 1'b0;
    bus.AliensAlive    = 6'd55;
    frames_no_step(3, "go_nostep");
    chk("go_hold_anim", 32'(bus.Anim_Frame), 32'd1);
    bus.Start = 1'b1;
    cyc();
    chk("go_idle_state", 32'(bus.Game_State), 32'd0);
    chk("go_idle_wave",  32'(bus.Wave_Num),   32'd0);
    repeat (5) cyc();
    chk("held_start_idle", 32'(bus.Game_State), 32'd0);
    bus.Start = 1'b0;
    cyc();
    bus.Start = 1'b1;
    cyc();
    chk("restart_state",   32'(bus.Game_State),   32'd1);
    chk("restart_pulse",   32'(bus.Wave_Restart), 32'd1);
    bus.Start = 1'b0;

    // Reset lands on the edge of the qualifying 57th tick.
    frames_no_step(56, "pre_reset_nostep");
    chk("pre_reset_note", 32'(bus.Step_Note), 32'd3);
    bus.Frame_Tick = 1'b1;
    rst_n          = 1'b0;
    cyc();
    bus.Frame_Tick = 1'b0;
    chk("rmid_step",    32'(bus.Step_En),      32'd0);
    chk("rmid_state",   32'(bus.Game_State),   32'd0);
    chk("rmid_anim",    32'(bus.Anim_Frame),   32'd0);
    chk("rmid_note",    32'(bus.Step_Note),    32'd0);
    chk("rmid_restart", 32'(bus.Wave_Restart), 32'd0);
    chk("rmid_wave",    32'(bus.Wave_Num),     32'd0);
    rst_n = 1'b1;
    cyc();
    chk("rmid_after_step", 32'(bus.Step_En), 32'd0);
    frames_no_step(3, "post_reset_nostep");
    chk("post_reset_state", 32'(bus.Game_State), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
